gray_code_converter_pipe: RTL

//  Parametrised, pipelined bidirectional binary<->Gray converter with valid/ready handshake.
//  Per-transfer mode bit selects binary->Gray or Gray->binary.

---
 rtl/gray_code_converter_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gray_code_converter_pipe.sv
// gray_code_converter_pipe
// Two-stage, back-pressurable binary<->Gray converter with a valid/ready
// handshake on both sides. Each word carries its own mode bit:
//   0 = binary->Gray, 1 = Gray->binary.
// S1 registers the raw {mode, data}; the conversion is combinational between
// S1 and S2, and S2 drives the out_* ports.
// Optional feature: define GRAY_STEP_CHECK_EN to track the Gray-domain word
// of every output transfer and pulse step_err for one cycle when two
// consecutive words differ in more than one bit. Without the macro step_err
// is tied low and no tracking logic exists.

module gray_code_converter_pipe #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             step_err
);

  logic             s1_valid;
  logic             s1_mode;
  logic [WIDTH-1:0] s1_data;

  logic             s2_en;
  logic             s1_to_s2;
  logic             in_xfer;

  logic [WIDTH-1:0] bin_to_gray;
  logic [WIDTH-1:0] gray_to_bin;
  logic [WIDTH-1:0] conv_data;

  // S2 can take a word when it is empty or its word leaves this cycle;
  // S1 can take a word when it is empty or its word moves on to S2.
  assign s2_en    = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_en;
  assign in_xfer  = in_valid && in_ready;
  assign s1_to_s2 = s1_valid && s2_en;

  // Binary->Gray: each bit is the XOR of itself and its left neighbour.
  always_comb begin
    bin_to_gray = '0;
    bin_to_gray[WIDTH-1] = s1_data[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_to_gray[i] = s1_data[i+1] ^ s1_data[i];
    end
  end

  // Gray->binary: running XOR of the Gray bits from the MSB downwards.
  always_comb begin
    logic acc;
    gray_to_bin = '0;
    acc = s1_data[WIDTH-1];
    gray_to_bin[WIDTH-1] = acc;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      acc = acc ^ s1_data[i];
      gray_to_bin[i] = acc;
    end
  end

  assign conv_data = s1_mode ? gray_to_bin : bin_to_gray;

  // S1 occupancy: filled by an input transfer, emptied when it drains to S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
    end else if (s1_to_s2) begin
      s1_valid <= 1'b0;
    end
  end

  // S1 payload loads only on an accepted input so idle-bus junk never enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode <= 1'b0;
      s1_data <= '0;
    end else if (in_xfer) begin
      s1_mode <= in_mode;
      s1_data <= in_data;
    end
  end

  // S2 occupancy follows S1 whenever S2 is free to advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
    end
  end

  // S2 payload loads only when S1 hands over a word; held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mode <= 1'b0;
      out_data <= '0;
    end else if (s1_to_s2) begin
      out_mode <= s1_mode;
      out_data <= conv_data;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic             out_xfer;
  logic [WIDTH-1:0] s2_orig;
  logic [WIDTH-1:0] last_gray;
  logic             have_last;
  logic [WIDTH-1:0] gray_word;
  logic [WIDTH-1:0] gray_diff;
  logic             multi_bit;

  assign out_xfer  = out_valid && out_ready;
  // A Gray->binary word's Gray form is the original input, so S2 keeps it.
  assign gray_word = out_mode ? s2_orig : out_data;
  assign gray_diff = last_gray ^ gray_word;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_bit = (gray_diff & (gray_diff - WIDTH'(1))) != '0;

  // Keep the unconverted word alongside the S2 result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_orig <= '0;
    end else if (s1_to_s2) begin
      s2_orig <= s1_data;
    end
  end

  // Remember the last transferred Gray word and flag multi-bit steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gray <= '0;
      have_last <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      step_err <= out_xfer && have_last && multi_bit;
      if (out_xfer) begin
        last_gray <= gray_word;
        have_last <= 1'b1;
      end
    end
  end
`else
  assign step_err = 1'b0;
`endif

endmodule
